// File: rtl/data_memory_mmio.sv
// data_memory_mmio
// Data memory with memory-mapped IO on the RV32I load/store path.
// Byte/half/word loads and stores reach an inferred RAM, a bank of output
// registers, a synchronised input port with sticky rising-edge latches, and
// a status block. Misaligned accesses are suppressed and raise a sticky fault.
// Every load has a fixed one-cycle latency, whatever region it targets.
//
// Ports:
//   clock          rising-edge clock for all state
//   reset          synchronous, active-high
//   address        byte address; [13:12] selects RAM/input/output/status
//   mem_mode       00 byte, 01 half, 10 word, 11 treated as word
//   mem_unsigned   zero-extend byte/half loads when high
//   wren           store strobe for the current cycle
//   data           store data, LSB-aligned
//   q              load result, valid the cycle after the address
//   fault          sticky misaligned-access flag
//   io_input_bus   asynchronous external inputs
//   io_output_bus  output registers concatenated, register 0 in [31:0]
module data_memory_mmio #(
    parameter int RAM_AW = 10,
    parameter int N_OUT  = 2,
    parameter int IN_W   = 14
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          address,
    input  logic [1:0]           mem_mode,
    input  logic                 mem_unsigned,
    input  logic                 wren,
    input  logic [31:0]          data,
    output logic [31:0]          q,
    output logic                 fault,
    input  logic [IN_W-1:0]      io_input_bus,
    output logic [N_OUT*32-1:0]  io_output_bus
);

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    localparam logic [1:0] RGN_RAM  = 2'b00;
    localparam logic [1:0] RGN_IN   = 2'b01;
    localparam logic [1:0] RGN_OUT  = 2'b10;
    localparam logic [1:0] RGN_STAT = 2'b11;

    // Expand four byte enables into a 32-bit lane mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = be[i] ? 8'hFF : 8'h00;
        end
        return m;
    endfunction

    // Shift the addressed bytes down to bit 0, then mask and extend per mode.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [1:0]  mode,
                                                input logic        uns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (mode)
            MEM_BYTE: res = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            MEM_HALF: res = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            MEM_WORD: res = sh;
            default:  res = sh;
        endcase
        return res;
    endfunction

    // Decode and store-path signals
    logic [1:0]        off_s;
    logic [1:0]        region_s;
    logic [1:0]        reg_idx_s;
    logic [RAM_AW-1:0] ram_idx_s;
    logic              legal_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_s;
    logic [31:0]       wmask_s;
    logic              store_s;

    // Storage
    logic [31:0]       mem_q [2**RAM_AW];
    logic [31:0]       ram_rd_q;
    logic [31:0]       out_q [N_OUT];
    logic [31:0]       out_d [N_OUT];
    logic [IN_W-1:0]   meta_q;
    logic [IN_W-1:0]   sync_q;
    logic [IN_W-1:0]   latch_q;
    logic [IN_W-1:0]   latch_d;
    logic              fault_q;
    logic              fault_d;

    // Load pipeline
    logic [31:0]       other_q;
    logic [31:0]       other_d;
    logic              rd_ram_q;
    logic              rd_ok_q;
    logic [1:0]        off_q;
    logic [1:0]        mode_q;
    logic              uns_q;

    logic [31:0]       sync_ext_s;
    logic [31:0]       latch_ext_s;
    logic [31:0]       clr_word_s;
    logic [IN_W-1:0]   edge_s;
    logic              fault_clr_s;
    logic              unused_s;

    // Address decode, alignment check and store lane generation.
    always_comb begin
        off_s     = address[1:0];
        region_s  = address[13:12];
        reg_idx_s = address[3:2];
        ram_idx_s = address[RAM_AW+1:2];
        case (mem_mode)
            MEM_BYTE: begin
                legal_s = 1'b1;
                be_s    = 4'b0001 << off_s;
            end
            MEM_HALF: begin
                legal_s = (off_s != 2'b11);
                be_s    = 4'b0011 << off_s;
            end
            MEM_WORD: begin
                legal_s = (off_s == 2'b00);
                be_s    = 4'b1111;
            end
            default: begin
                legal_s = (off_s == 2'b00);
                be_s    = 4'b1111;
            end
        endcase
        wdata_s = data << {off_s, 3'b000};
        wmask_s = lane_mask(be_s);
        store_s = wren & legal_s & ~reset;
    end

    // Widen the input-side registers to bus width for readback.
    always_comb begin
        sync_ext_s             = 32'h0;
        latch_ext_s            = 32'h0;
        sync_ext_s[IN_W-1:0]   = sync_q;
        latch_ext_s[IN_W-1:0]  = latch_q;
    end

    // Read mux for the non-RAM regions, sampled with the address.
    always_comb begin
        other_d = 32'h0;
        case (region_s)
            RGN_IN: begin
                if (reg_idx_s == 2'd0) begin
                    other_d = sync_ext_s;
                end else begin
                    other_d = 32'h0;
                end
            end
            RGN_OUT: begin
                for (int k = 0; k < N_OUT; k++) begin
                    if (reg_idx_s == k[1:0]) begin
                        other_d = out_q[k];
                    end else begin
                        other_d = other_d;
                    end
                end
            end
            RGN_STAT: begin
                case (reg_idx_s)
                    2'd0:    other_d = latch_ext_s;
                    2'd1:    other_d = {31'h0, fault_q};
                    default: other_d = 32'h0;
                endcase
            end
            default: other_d = 32'h0;
        endcase
    end

    // Output register next state: byte-enabled merge for the addressed word.
    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            if (store_s && (region_s == RGN_OUT) && (reg_idx_s == k[1:0])) begin
                out_d[k] = (out_q[k] & ~wmask_s) | (wdata_s & wmask_s);
            end else begin
                out_d[k] = out_q[k];
            end
        end
    end

    // Edge latches and fault: a new edge beats a clear, a misalignment beats a clear.
    always_comb begin
        // An edge is seen as the synchronised value is about to become 1.
        edge_s = meta_q & ~sync_q;
        if (store_s && (region_s == RGN_STAT) && (reg_idx_s == 2'd0)) begin
            clr_word_s = wdata_s & wmask_s;
        end else begin
            clr_word_s = 32'h0;
        end
        fault_clr_s = store_s && (region_s == RGN_STAT) && (reg_idx_s == 2'd1)
                      && be_s[0] && wdata_s[0];
        latch_d = (latch_q & ~clr_word_s[IN_W-1:0]) | edge_s;
        fault_d = ~legal_s | (fault_q & ~fault_clr_s);
    end

    // RAM: byte-enabled write; the read captures the pre-write word.
    always_ff @(posedge clock) begin
        if (store_s && (region_s == RGN_RAM)) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_q[ram_idx_s][i*8 +: 8] <= wdata_s[i*8 +: 8];
                end
            end
        end
        ram_rd_q <= mem_q[ram_idx_s];
    end

    // Control, IO and load-pipeline registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q   <= '0;
            sync_q   <= '0;
            latch_q  <= '0;
            fault_q  <= 1'b0;
            other_q  <= 32'h0;
            rd_ram_q <= 1'b0;
            rd_ok_q  <= 1'b0;
            off_q    <= 2'b00;
            mode_q   <= 2'b00;
            uns_q    <= 1'b0;
            for (int k = 0; k < N_OUT; k++) begin
                out_q[k] <= 32'h0;
            end
        end else begin
            meta_q   <= io_input_bus;
            sync_q   <= meta_q;
            latch_q  <= latch_d;
            fault_q  <= fault_d;
            other_q  <= other_d;
            rd_ram_q <= (region_s == RGN_RAM);
            rd_ok_q  <= legal_s;
            off_q    <= off_s;
            mode_q   <= mem_mode;
            uns_q    <= mem_unsigned;
            for (int k = 0; k < N_OUT; k++) begin
                out_q[k] <= out_d[k];
            end
        end
    end

    // Load result: misaligned loads and the post-reset cycle read as zero.
    always_comb begin
        if (rd_ok_q) begin
            q = load_extend(rd_ram_q ? ram_rd_q : other_q, off_q, mode_q, uns_q);
        end else begin
            q = 32'h0;
        end
    end

    assign fault = fault_q;

    genvar g;
    generate
        for (g = 0; g < N_OUT; g++) begin : g_obus
            assign io_output_bus[g*32 +: 32] = out_q[g];
        end
    endgenerate

    assign unused_s = ^{address, clr_word_s};

endmodule

// File: tb/tb_data_memory_mmio.sv
module tb_data_memory_mmio;

    localparam int RAM_AW = 8;
    localparam int N_OUT  = 2;
    localparam int IN_W   = 14;
    localparam int NWORDS = 1 << RAM_AW;

    logic                clock;
    logic                reset;
    logic [31:0]         address;
    logic [1:0]          mem_mode;
    logic                mem_unsigned;
    logic                wren;
    logic [31:0]         data;
    logic [31:0]         q;
    logic                fault;
    logic [IN_W-1:0]     io_input_bus;
    logic [N_OUT*32-1:0] io_output_bus;

    int n_checks;
    int n_err;
    logic chk_en;

    // Reference state (post-edge view)
    logic [31:0]     m_ram [NWORDS];
    logic            m_ram_ok [NWORDS];
    logic [31:0]     m_out [N_OUT];
    logic [IN_W-1:0] m_latch;
    logic            m_fault;
    logic [31:0]     m_q;
    logic            m_qv;
    logic [IN_W-1:0] h1;   // input bus as sampled one edge ago
    logic [IN_W-1:0] h2;   // input bus as sampled two edges ago

    data_memory_mmio #(.RAM_AW(RAM_AW), .N_OUT(N_OUT), .IN_W(IN_W)) dut (
        .clock(clock), .reset(reset), .address(address), .mem_mode(mem_mode),
        .mem_unsigned(mem_unsigned), .wren(wren), .data(data), .q(q),
        .fault(fault), .io_input_bus(io_input_bus), .io_output_bus(io_output_bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply the rules to the inputs present at this edge.
    task model_step();
        int size, off, k, lane;
        logic [31:0] rd, sh, mask;
        logic [7:0] b;
        logic legal;
        logic [IN_W-1:0] edges, clr;
        logic fclr;
        if (reset) begin
            for (int i = 0; i < N_OUT; i++) m_out[i] = 32'h0;
            m_latch = '0;
            m_fault = 1'b0;
            m_q     = 32'h0;
            m_qv    = 1'b1;
            h1      = '0;
            h2      = '0;
        end else begin
            off   = int'(address[1:0]);
            size  = (mem_mode == 2'd0) ? 1 : ((mem_mode == 2'd1) ? 2 : 4);
            legal = (off + size <= 4);
            k     = int'(address[3:2]);
            rd    = 32'h0;
            m_qv  = 1'b1;
            case (address[13:12])
                2'd0: begin
                    rd   = m_ram[address[RAM_AW+1:2]];
                    m_qv = m_ram_ok[address[RAM_AW+1:2]];
                end
                2'd1: if (k == 0) rd = 32'(h2);
                2'd2: if (k < N_OUT) rd = m_out[k];
                default: begin
                    if (k == 0) rd = 32'(m_latch);
                    else if (k == 1) rd = {31'h0, m_fault};
                end
            endcase
            if (!legal) begin
                m_q  = 32'h0;
                m_qv = 1'b1;
            end else begin
                sh = rd >> (8 * off);
                if (size == 4) m_q = sh;
                else begin
                    mask = (size == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
                    m_q  = sh & mask;
                    if (!mem_unsigned && m_q[8*size-1]) m_q = m_q | ~mask;
                end
            end
            edges = h1 & ~h2;
            clr   = '0;
            fclr  = 1'b0;
            if (wren && legal) begin
                if (address[13:12] == 2'd0 && size == 4)
                    m_ram_ok[address[RAM_AW+1:2]] = 1'b1;
                for (int j = 0; j < size; j++) begin
                    lane = off + j;
                    b    = data[8*j +: 8];
                    case (address[13:12])
                        2'd0: m_ram[address[RAM_AW+1:2]][8*lane +: 8] = b;
                        2'd2: if (k < N_OUT) m_out[k][8*lane +: 8] = b;
                        2'd3: begin
                            if (k == 0) begin
                                for (int t = 0; t < 8; t++)
                                    if (8*lane + t < IN_W && b[t]) clr[8*lane+t] = 1'b1;
                            end else if (k == 1 && lane == 0 && b[0]) fclr = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            m_latch = (m_latch & ~clr) | edges;
            m_fault = !legal || (m_fault && !fclr);
            h2 = h1;
            h1 = io_input_bus;
        end
    endtask

    task cyc(input logic [31:0] a, input logic [1:0] m, input logic u,
             input logic w, input logic [31:0] d);
        address = a; mem_mode = m; mem_unsigned = u; wren = w; data = d;
        @(posedge clock);
        model_step();
        #1;
    endtask

    task lw(input logic [31:0] a);
        cyc(a, 2'd2, 1'b0, 1'b0, 32'h0);
    endtask

    // Per-cycle comparison against the reference model.
    initial begin
        forever begin
            @(negedge clock);
            if (chk_en) begin
                if (m_qv) check("q_model", {32'h0, q}, {32'h0, m_q});
                check("fault_model", {63'h0, fault}, {63'h0, m_fault});
                check("obus_model", io_output_bus, {m_out[1], m_out[0]});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, r2;
        logic seen;
        n_checks = 0; n_err = 0; chk_en = 1'b0;
        for (int i = 0; i < NWORDS; i++) begin
            m_ram[i] = 32'h0; m_ram_ok[i] = 1'b0;
        end
        io_input_bus = '0;
        reset = 1'b1;
        cyc(32'h0000_2000, 2'd2, 1'b0, 1'b1, 32'hFFFF_FFFF);
        cyc(32'h0000_2000, 2'd2, 1'b0, 1'b1, 32'hFFFF_FFFF);
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_q", {32'h0, q}, 64'h0);
        check("rst_obus", io_output_bus, 64'h0);

        for (int i = 0; i < NWORDS; i++)
            cyc(32'(i * 4), 2'd2, 1'b0, 1'b1, 32'hA500_0000 | 32'(i));

        // RAM byte/half loads
        cyc(32'h10, 2'd2, 1'b0, 1'b1, 32'h80FF_7F01);
        cyc(32'h11, 2'd0, 1'b0, 1'b0, 32'h0); check("lb_11", {32'h0, q}, 64'h0000_007F);
        cyc(32'h12, 2'd0, 1'b0, 1'b0, 32'h0); check("lb_12", {32'h0, q}, 64'hFFFF_FFFF);
        cyc(32'h13, 2'd0, 1'b1, 1'b0, 32'h0); check("lbu_13", {32'h0, q}, 64'h0000_0080);
        cyc(32'h12, 2'd1, 1'b0, 1'b0, 32'h0); check("lh_12", {32'h0, q}, 64'hFFFF_80FF);
        cyc(32'h11, 2'd1, 1'b0, 1'b0, 32'h0); check("lh_11", {32'h0, q}, 64'hFFFF_FF7F);
        cyc(32'h12, 2'd1, 1'b1, 1'b0, 32'h0); check("lhu_12", {32'h0, q}, 64'h0000_80FF);
        cyc(32'h11, 2'd0, 1'b0, 1'b1, 32'h0000_00C3);
        lw(32'h10); check("sb_merge", {32'h0, q}, 64'h80FF_C301);

        // Misalignment
        cyc(32'h6, 2'd2, 1'b0, 1'b1, 32'h1234_5678);
        check("mis_fault", {63'h0, fault}, 64'h1);
        lw(32'h4); check("mis_ram_kept", {32'h0, q}, 64'hA500_0001);
        cyc(32'h3, 2'd1, 1'b0, 1'b0, 32'h0); check("mis_lh_zero", {32'h0, q}, 64'h0);
        cyc(32'h3004, 2'd0, 1'b0, 1'b1, 32'h1);
        check("fault_clr", {63'h0, fault}, 64'h0);

        // Output bank
        cyc(32'h2005, 2'd0, 1'b0, 1'b1, 32'hAB);
        check("obus_47_40", {56'h0, io_output_bus[47:40]}, 64'hAB);
        cyc(32'h2008, 2'd2, 1'b0, 1'b1, 32'hFFFF_FFFF);
        lw(32'h2008); check("out_k2_zero", {32'h0, q}, 64'h0);
        lw(32'h2004); check("out_k1_rd", {32'h0, q}, 64'h0000_AB00);
        cyc(32'h2000, 2'd2, 1'b0, 1'b1, 32'h1122_3344);
        check("rbw_old", {32'h0, q}, 64'h0);
        lw(32'h2000); check("rbw_new", {32'h0, q}, 64'h1122_3344);

        // Reset concurrent with a store
        cyc(32'h1, 2'd2, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        cyc(32'h2000, 2'd2, 1'b0, 1'b1, 32'hFFFF_FFFF);
        reset = 1'b0;
        check("rst2_obus", io_output_bus, 64'h0);
        check("rst2_q", {32'h0, q}, 64'h0);
        check("rst2_fault", {63'h0, fault}, 64'h0);

        // Input synchroniser and edge latches
        io_input_bus = 14'h0008;
        seen = 1'b0;
        for (int n = 0; n < 3; n++) begin
            lw(32'h1000);
            if (q[3]) seen = 1'b1;
        end
        check("in_latency", {63'h0, seen}, 64'h1);
        lw(32'h3000); check("edge_latch", {32'h0, q}, 64'h8);
        io_input_bus = 14'h0000;
        for (int n = 0; n < 3; n++) lw(32'h0);
        cyc(32'h3000, 2'd2, 1'b0, 1'b1, 32'h8);
        lw(32'h3000); check("w1c", {32'h0, q}, 64'h0);
        io_input_bus = 14'h0008;
        lw(32'h0);
        cyc(32'h3000, 2'd2, 1'b0, 1'b1, 32'h8);
        lw(32'h3000); check("set_wins", {32'h0, q}, 64'h8);

        // Aliasing
        cyc(32'h0, 2'd2, 1'b0, 1'b1, 32'hDEAD_BEEF);
        lw(32'h0000_0400); check("alias_400", {32'h0, q}, 64'hDEAD_BEEF);
        lw(32'h0000_4000); check("alias_4000", {32'h0, q}, 64'hDEAD_BEEF);

        // Randomised traffic checked by the per-cycle model comparison
        for (int n = 0; n < 3000; n++) begin
            r  = $urandom();
            r2 = $urandom();
            if ($urandom_range(0, 3) == 0) io_input_bus = io_input_bus ^ IN_W'($urandom());
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0)
                cyc(32'h3004, 2'd0, 1'b0, 1'b1, 32'h1);
            else
                cyc(r, r2[1:0], r2[2], r2[3], $urandom());
        end
        reset = 1'b0;
        lw(32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/data_memory_mmio.md
# data_memory_mmio

Parametrised data memory with memory-mapped IO for the RV32I core, sitting on the load/store path after the ALU. It provides byte/halfword/word load and store to an inferred RAM, a configurable bank of output registers, synchronised input sampling with sticky rising-edge latches, and misaligned-access fault detection. All loads have a fixed one-cycle latency regardless of region.

## Interface
Parameters:
- RAM_AW, 10: RAM word-address bits; RAM holds 2^RAM_AW 32-bit words.
- N_OUT, 2: number of 32-bit output registers (1..4).
- IN_W, 14: input bus width (1..32).

Ports (name, direction, width, meaning):
- clock  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- address  in  32  byte address from ALU.
- mem_mode  in  2  MEM_BYTE / MEM_HALF / MEM_WORD (mem_modes.h encodings); other codes act as MEM_WORD.
- mem_unsigned  in  1  high: zero-extend byte/half loads.
- wren  in  1  store strobe for the current cycle.
- data  in  32  store data, LSB-aligned (byte in [7:0], half in [15:0]).
- q  out  32  load result, extended per mode.
- fault  out  1  sticky misaligned-access flag.
- io_input_bus  in  IN_W  asynchronous external inputs.
- io_output_bus  out  N_OUT*32  output registers concatenated, register 0 in [31:0].

## Operation
- Region decode on address[13:12]: 00 RAM, 01 input, 10 output registers, 11 status.
- Word index = address[RAM_AW+1:2] for RAM (higher bits alias); address[3:2] for other regions. Byte offset = address[1:0].
- Alignment: byte always legal; half legal when offset ∈ {0,1,2}; word legal only at offset 0. Illegal access: store suppressed in every region, load returns 0, fault set.
- Store byte enables: byte 0001<<offset, half 0011<<offset, word 1111; data lane-shifted by offset*8.
- RAM: byte-enabled write; synchronous read of the addressed word.
- Input region: io_input_bus passes through a 2-flop synchroniser; word 0 read returns synchronised bits zero-extended; other words read 0; writes ignored.
- Edge latches (IN_W bits): bit i sets on a rising edge of synchronised bit i (current 1, previous 0).
- Output region: word k < N_OUT byte-enabled writable and readable; k ≥ N_OUT reads 0, writes ignored.
- Status word 0: read returns edge latches; a store clears each latch bit written as 1 (write-1-to-clear, byte enables honoured). Status word 1: read returns {31'b0, fault}; a store with data[0]=1 to byte 0 clears fault. Status words 2-3 read 0.
- Load path: selected word shifted right by offset*8, then masked to 8/16 bits and sign- or zero-extended per registered mem_mode/mem_unsigned.

## Timing
- Reset (synchronous): q=0, fault=0, all output registers 0 (io_output_bus=0), edge latches 0, synchroniser and previous-sample flops 0, address/mode/unsigned pipeline registers 0.
- Stores commit at the rising edge where wren is sampled; visible on io_output_bus the following cycle.
- Load latency exactly 1: address/mode/unsigned sampled at edge N; q valid after edge N until edge N+1. q is combinational from registered state.
- Read during a store to the same address in the same cycle returns the old data (read-before-write) for every region.
- Input latency: io_input_bus change to input-region read value ≤ 3 cycles; edge latch sets at the same edge the synchronised value first reads 1.
- Edge-latch set and write-1-to-clear on the same bit in the same cycle: set wins.
- Misaligned access and fault-clear write in the same cycle: fault remains set.
- reset asserted concurrently with wren: store discarded, reset values win.

## Test plan
- Reset: drive reset 1 cycle with wren=1, address=0x2000, data=0xFFFFFFFF -> io_output_bus=0, q=0, fault=0 afterwards.
- RAM byte/half: SW 0x80FF7F01 @0x10; LB @0x11 -> 0x0000007F; LB @0x12 -> 0xFFFFFFFF; LBU @0x13 -> 0x00000080; LH @0x12 -> 0xFFFF80FF; each one cycle after address.
- Misaligned: SW @0x0006 with data 0x12345678 -> fault=1, RAM word 1 unchanged; LH @0x0003 -> q=0; SB 0x01 @0x3004 -> fault=0.
- Output bank (N_OUT=2): SB 0xAB @0x2005 -> io_output_bus[47:40]=0xAB next cycle; SW @0x2008 -> ignored; LW @0x2008 -> 0.
- Inputs/edges: io_input_bus bit 3 0->1 -> LW @0x1000 shows bit 3 set within 3 cycles; LW @0x3000 -> 0x00000008; SW 0x8 @0x3000 in the same cycle as a new bit-3 edge -> latch stays 1.
- Aliasing: SW 0xDEADBEEF @0x0000 then LW @(1<<(RAM_AW+2)) within region 00 -> 0xDEADBEEF.
